// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer for the DE-board LED bank: a tick divider paces a small state
// machine that plays one of four 18-bit patterns on {LEDR, LEDG}, chosen by synchronised switches.
module led_pattern_sequencer #(
   parameter int TICK_DIV = 12500000,
   parameter int CNT_W    = $clog2(TICK_DIV)
) (
   input  logic       CLOCK_50,
   input  logic       RST_N,
   input  logic [1:0] mode,
   input  logic       pause,
   output logic [9:0] LEDR,
   output logic [7:0] LEDG,
   output logic       tick_out
);

   typedef enum logic {IDLE, RUN} state_t;
   typedef enum logic {DIR_DOWN, DIR_UP} dir_t;
   typedef enum logic [1:0] {M_ALT, M_WALK, M_BOUNCE, M_COUNT} mode_t;

   localparam logic [4:0]  POS_TOP  = 5'd17;
   localparam logic [17:0] ONE_HOT0 = 18'd1;

   logic [1:0]       mode_s1_q, mode_s_q;
   logic             pause_s1_q, pause_s_q;
   mode_t            mode_q, mode_d;
   state_t           state_q, state_d;
   dir_t             dir_q, dir_d;
   logic [4:0]       pos_q, pos_d;
   logic [17:0]      led_q, led_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             mode_chg;
   logic             tick;
   logic [4:0]       pos_n;

   assign mode_chg = (mode_s_q != mode_q);
   assign tick     = (cnt_q == CNT_W'(TICK_DIV - 1)) && !pause_s_q && !mode_chg;

   // NOTE: every flop, synchronisers included, takes the async reset so the board
   // powers up dark and deterministic; sequential state is written only with <=.
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         mode_s1_q  <= '0;
         mode_s_q   <= '0;
         pause_s1_q <= 1'b0;
         pause_s_q  <= 1'b0;
         mode_q     <= M_ALT;
         state_q    <= IDLE;
         dir_q      <= DIR_DOWN;
         pos_q      <= POS_TOP;
         led_q      <= '0;
         cnt_q      <= '0;
      end else begin
         mode_s1_q  <= mode;
         mode_s_q   <= mode_s1_q;
         pause_s1_q <= pause;
         pause_s_q  <= pause_s1_q;
         mode_q     <= mode_d;
         state_q    <= state_d;
         dir_q      <= dir_d;
         pos_q      <= pos_d;
         led_q      <= led_d;
         cnt_q      <= cnt_d;
      end
   end

   // NOTE: all next-state signals get their hold value first, so no path can infer a latch.
   always_comb begin
      mode_d  = mode_q;
      state_d = state_q;
      dir_d   = dir_q;
      pos_d   = pos_q;
      led_d   = led_q;
      cnt_d   = cnt_q;
      pos_n   = pos_q;

      if (mode_chg) begin
         // A switch change restarts from a dark display, even while paused.
         mode_d  = mode_t'(mode_s_q);
         state_d = IDLE;
         led_d   = '0;
         cnt_d   = '0;
         pos_d   = POS_TOP;
         dir_d   = DIR_DOWN;
      end else if (!pause_s_q) begin
         if (!tick) begin
            cnt_d = cnt_q + CNT_W'(1);
         end else begin
            cnt_d = '0;
            unique case (state_q)
               IDLE: begin
                  state_d = RUN;
                  pos_d   = POS_TOP;
                  dir_d   = DIR_DOWN;
                  unique case (mode_q)
                     M_ALT:    led_d = 18'h2AAAA;
                     M_WALK:   led_d = 18'h20000;
                     M_BOUNCE: led_d = ONE_HOT0 << POS_TOP;
                     M_COUNT:  led_d = '0;
                  endcase
               end
               RUN: begin
                  unique case (mode_q)
                     M_ALT:  led_d = ~led_q;
                     M_WALK: led_d = {led_q[0], led_q[17:1]};
                     M_BOUNCE: begin
                        // Direction flips on arrival so each end shows for one step only.
                        if (dir_q == DIR_DOWN) begin
                           pos_n = pos_q - 5'd1;
                           if (pos_n == 5'd0) dir_d = DIR_UP;
                        end else begin
                           pos_n = pos_q + 5'd1;
                           if (pos_n == POS_TOP) dir_d = DIR_DOWN;
                        end
                        pos_d = pos_n;
                        led_d = ONE_HOT0 << pos_n;
                     end
                     M_COUNT: led_d = led_q + 18'd1;
                  endcase
               end
            endcase
         end
      end
   end

   assign LEDR     = led_q[17:8];
   assign LEDG     = led_q[7:0];
   assign tick_out = tick;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with TICK_DIV=4: reset, all four patterns,
// pause freeze, mode change coinciding with a tick, and asynchronous reset mid-bounce.
module tb_led_pattern_sequencer;

   logic       CLOCK_50 = 1'b0;
   logic       RST_N    = 1'b0;
   logic [1:0] mode     = 2'd0;
   logic       pause    = 1'b0;
   logic [9:0] LEDR;
   logic [7:0] LEDG;
   logic       tick_out;
   logic [17:0] led_v;

   int n_tests = 0;
   int n_fail  = 0;

   led_pattern_sequencer #(.TICK_DIV(4)) dut (
      .CLOCK_50 (CLOCK_50),
      .RST_N    (RST_N),
      .mode     (mode),
      .pause    (pause),
      .LEDR     (LEDR),
      .LEDG     (LEDG),
      .tick_out (tick_out)
   );

   always #5 CLOCK_50 = ~CLOCK_50;
   assign led_v = {LEDR, LEDG};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] one_hot(input int p);
      logic [17:0] v;
      v = 18'd1;
      return v << p;
   endfunction

   function automatic int bounce_pos(input int i);
      int k;
      k = i % 34;
      return (k <= 17) ? 17 - k : k - 17;
   endfunction

   // Waits (bounded) for the next tick, then checks the LED value after that tick's edge.
   task automatic next_step(input logic [17:0] exp, input bit chk_gap, input string tag);
      int n;
      n = 0;
      while (tick_out !== 1'b1 && n < 16) begin
         @(negedge CLOCK_50);
         n++;
      end
      check({tag, "_tick"}, 32'(tick_out), 32'd1);
      if (chk_gap) check({tag, "_gap"}, n, 32'd3);
      @(negedge CLOCK_50);
      check({tag, "_led"}, 32'(led_v), 32'(exp));
   endtask

   task automatic do_reset(input logic [1:0] m);
      @(negedge CLOCK_50);
      RST_N = 1'b0;
      mode  = m;
      pause = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check("rst_led", 32'(led_v), 32'd0);
      check("rst_tick", 32'(tick_out), 32'd0);
      RST_N = 1'b1;
   endtask

   initial begin
      // Mode 0 from reset: first tick in the 4th cycle, then alternate every 4 cycles.
      do_reset(2'd0);
      @(negedge CLOCK_50);
      check("alt_c1_led", 32'(led_v), 32'd0);
      check("alt_c1_tick", 32'(tick_out), 32'd0);
      @(negedge CLOCK_50);
      check("alt_c2_tick", 32'(tick_out), 32'd0);
      @(negedge CLOCK_50);
      check("alt_c3_tick", 32'(tick_out), 32'd1);
      check("alt_c3_led", 32'(led_v), 32'd0);
      @(negedge CLOCK_50);
      check("alt_c4_led", 32'(led_v), 32'h2AAAA);
      check("alt_c4_tick", 32'(tick_out), 32'd0);
      next_step(18'h15555, 1'b1, "alt1");
      next_step(18'h2AAAA, 1'b1, "alt2");
      next_step(18'h15555, 1'b1, "alt3");

      // Mode 1 from reset: walk right through 18 positions and wrap.
      do_reset(2'd1);
      for (int i = 0; i <= 18; i++)
         next_step(18'h20000 >> (i % 18), (i != 0), $sformatf("walk%0d", i));

      // Pause during walk: the pending step completes, then 1 count is held.
      begin
         int n;
         n = 0;
         while (tick_out !== 1'b1 && n < 16) begin
            @(negedge CLOCK_50);
            n++;
         end
         check("pz_tick0", 32'(tick_out), 32'd1);
         pause = 1'b1;
         @(negedge CLOCK_50);
         check("pz_led1", 32'(led_v), 32'h10000);
         for (int k = 2; k <= 24; k++) begin
            @(negedge CLOCK_50);
            check($sformatf("pz_tick%0d", k), 32'(tick_out), 32'd0);
            check($sformatf("pz_led%0d", k), 32'(led_v), 32'h10000);
            if (k == 21) pause = 1'b0;
         end
         @(negedge CLOCK_50);
         check("pz_resume_tick", 32'(tick_out), 32'd1);
         @(negedge CLOCK_50);
         check("pz_resume_led", 32'(led_v), 32'h08000);
      end

      // Mode change 1->3 lands exactly on a tick cycle: tick suppressed, display cleared.
      begin
         int n;
         n = 0;
         while (tick_out !== 1'b1 && n < 16) begin
            @(negedge CLOCK_50);
            n++;
         end
         check("mc_tick0", 32'(tick_out), 32'd1);
         @(negedge CLOCK_50);
         check("mc_led1", 32'(led_v), 32'h04000);
         @(negedge CLOCK_50);
         mode = 2'd3;
         repeat (2) @(negedge CLOCK_50);
         check("mc_suppressed_tick", 32'(tick_out), 32'd0);
         check("mc_led4", 32'(led_v), 32'h04000);
         @(negedge CLOCK_50);
         check("mc_led_cleared", 32'(led_v), 32'd0);
         repeat (2) @(negedge CLOCK_50);
         check("mc_tick7", 32'(tick_out), 32'd0);
         @(negedge CLOCK_50);
         check("mc_tick8", 32'(tick_out), 32'd1);
         @(negedge CLOCK_50);
         check("mc_count_init", 32'(led_v), 32'd0);
      end

      // Mode 3 counting.
      for (int i = 1; i <= 5; i++)
         next_step(18'(i), 1'b1, $sformatf("cnt%0d", i));

      // Mode 2 from reset: bounce 17..0..17..16.
      do_reset(2'd2);
      for (int i = 0; i <= 35; i++)
         next_step(one_hot(bounce_pos(i)), (i != 0), $sformatf("bnc%0d", i));

      // Reset mid-bounce clears LEDs without a clock edge.
      @(negedge CLOCK_50);
      check("arst_before", 32'(led_v), 32'(one_hot(16)));
      #2 RST_N = 1'b0;
      #1;
      check("arst_led", 32'(led_v), 32'd0);
      check("arst_tick", 32'(tick_out), 32'd0);

      // Restart after reset behaves as power-up.
      do_reset(2'd0);
      next_step(18'h2AAAA, 1'b1, "restart");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
